// File: rtl/writeback_queue.sv
// In-order writeback FIFO between execute/memory stages and the 8x16 register bank.
// Optional combinational read bypass is enabled with `define FORWARD_EN.
module writeback_queue #(
  parameter int DATA_W       = 16,
  parameter int REG_ADDR_W   = 3,
  parameter int DEPTH        = 4,
  parameter int R0_HARDWIRED = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          alu_valid,
  input  logic [REG_ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          mem_ready,
  input  logic                          hold,
  output logic                          RegWrite,
  output logic [REG_ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]             dataToWrite,
  output logic [(2**REG_ADDR_W)-1:0]    pending,
`ifdef FORWARD_EN
  input  logic [REG_ADDR_W-1:0]         fwd_rs,
  input  logic [REG_ADDR_W-1:0]         fwd_rt,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_W-1:0]             fwd_data1,
  output logic [DATA_W-1:0]             fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**REG_ADDR_W;

  // Handshake: a producer transfer happens on a posedge where valid && ready;
  // ready depends only on registered occupancy and mem_valid, never on pops.

  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic             mem_acc, alu_acc;
  logic             mem_push, alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] count_next;

  assign mem_ready = (count < CNT_W'(DEPTH));
  assign alu_ready = (count <= CNT_W'(DEPTH - 2)) || ((count < CNT_W'(DEPTH)) && !mem_valid);

  assign mem_acc  = mem_valid && mem_ready;
  assign alu_acc  = alu_valid && alu_ready;
  // Writes to r0 complete the handshake but are dropped when r0 is hardwired.
  assign mem_push = mem_acc && !((R0_HARDWIRED != 0) && (mem_rd == '0));
  assign alu_push = alu_acc && !((R0_HARDWIRED != 0) && (alu_rd == '0));
  assign pop      = !hold && (count != '0);

  // The mem entry is older, so the alu entry lands in the slot after it.
  assign alu_slot   = wr_ptr + PTR_W'(mem_push);
  assign count_next = count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      RegWrite    <= 1'b0;
      rd          <= '0;
      dataToWrite <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (mem_push) begin
        rd_q[wr_ptr]   <= mem_rd;
        data_q[wr_ptr] <= mem_data;
      end
      if (alu_push) begin
        rd_q[alu_slot]   <= alu_rd;
        data_q[alu_slot] <= alu_data;
      end
      wr_ptr   <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
      count    <= count_next;
      RegWrite <= pop;
      if (pop) begin
        rd          <= rd_q[rd_ptr];
        dataToWrite <= data_q[rd_ptr];
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupied entries are the count slots starting at rd_ptr.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        pending[rd_q[rd_ptr + PTR_W'(k)]] = 1'b1;
      end
    end
    if (RegWrite) begin
      pending[rd] = 1'b1;
    end
    if (R0_HARDWIRED != 0) begin
      pending[0] = 1'b0;
    end
  end

`ifdef FORWARD_EN
  // Walk oldest to newest so the youngest matching entry wins; the output
  // stage is older than anything still in the FIFO.
  always_comb begin
    fwd_hit1  = pending[fwd_rs];
    fwd_hit2  = pending[fwd_rt];
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (RegWrite && (rd == fwd_rs)) fwd_data1 = dataToWrite;
    if (RegWrite && (rd == fwd_rt)) fwd_data2 = dataToWrite;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        if (rd_q[rd_ptr + PTR_W'(k)] == fwd_rs) fwd_data1 = data_q[rd_ptr + PTR_W'(k)];
        if (rd_q[rd_ptr + PTR_W'(k)] == fwd_rt) fwd_data2 = data_q[rd_ptr + PTR_W'(k)];
      end
    end
    if (!fwd_hit1) fwd_data1 = '0;
    if (!fwd_hit2) fwd_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue; expected values are hand-derived.
// Build with +define+FORWARD_EN to exercise the bypass ports as well.
module tb_writeback_queue;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        hold;
  logic        RegWrite;
  logic [2:0]  rd;
  logic [15:0] dataToWrite;
  logic [7:0]  pending;
  logic [2:0]  count;
`ifdef FORWARD_EN
  logic [2:0]  fwd_rs, fwd_rt;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
`endif

  int errors = 0;
  int checks = 0;

  writeback_queue dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold), .RegWrite(RegWrite), .rd(rd), .dataToWrite(dataToWrite),
    .pending(pending),
`ifdef FORWARD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .count(count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each posedge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [2:0] mr, input logic [15:0] md,
                       input logic av, input logic [2:0] ar, input logic [15:0] ad);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic expect_write(input string tag, input logic [2:0] r, input logic [15:0] d);
    check({tag, "_we"}, 32'(RegWrite), 32'd1);
    check({tag, "_rd"}, 32'(rd), 32'(r));
    check({tag, "_data"}, 32'(dataToWrite), 32'(d));
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
`ifdef FORWARD_EN
    fwd_rs = 3'd0; fwd_rt = 3'd0;
`endif
    idle();

    // 1: reset state
    step();
    reset_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_we", 32'(RegWrite), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_data", 32'(dataToWrite), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);

    // 2: single alu write, latency and pending window
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
    check("t2_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("t2_count1", 32'(count), 32'd1);
    check("t2_pend_q", 32'(pending), 32'h08);
    check("t2_we_early", 32'(RegWrite), 32'd0);
    step();
    expect_write("t2_w", 3'd3, 16'h1234);
    check("t2_pend_out", 32'(pending), 32'h08);
    check("t2_count0", 32'(count), 32'd0);
    step();
    check("t2_we_off", 32'(RegWrite), 32'd0);
    check("t2_pend_clr", 32'(pending), 32'h00);
    check("t2_rd_hold", 32'(rd), 32'd3);
    check("t2_data_hold", 32'(dataToWrite), 32'h1234);

    // 3: dual enqueue, mem entry older
    drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    check("t3_mem_ready", 32'(mem_ready), 32'd1);
    check("t3_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("t3_count", 32'(count), 32'd2);
    check("t3_pending", 32'(pending), 32'h24);
    step();
    expect_write("t3_w0", 3'd5, 16'hAAAA);
    check("t3_pending_mid", 32'(pending), 32'h24);
    step();
    expect_write("t3_w1", 3'd2, 16'h5555);
    step();
    check("t3_we_off", 32'(RegWrite), 32'd0);

    // 4: fill under hold, ready boundaries, then drain in order
    hold = 1'b1;
    drive(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022);
    step();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h0033);
    check("t4_c2_alu_ready", 32'(alu_ready), 32'd1);
    step();
    drive(1'b1, 3'd4, 16'h0044, 1'b1, 3'd7, 16'h0077);
    check("t4_c3_count", 32'(count), 32'd3);
    check("t4_c3_mem_ready", 32'(mem_ready), 32'd1);
    check("t4_c3_alu_ready", 32'(alu_ready), 32'd0);
    step();
    idle();
    check("t4_full_count", 32'(count), 32'd4);
    check("t4_full_mem_ready", 32'(mem_ready), 32'd0);
    check("t4_full_alu_ready", 32'(alu_ready), 32'd0);
    check("t4_full_pending", 32'(pending), 32'h1E);
    check("t4_hold_we", 32'(RegWrite), 32'd0);
    hold = 1'b0;
    step();
    expect_write("t4_w1", 3'd1, 16'h0011);
    check("t4_count3", 32'(count), 32'd3);
    step();
    expect_write("t4_w2", 3'd2, 16'h0022);
    step();
    expect_write("t4_w3", 3'd3, 16'h0033);
    step();
    expect_write("t4_w4", 3'd4, 16'h0044);
    step();
    check("t4_we_off", 32'(RegWrite), 32'd0);
    check("t4_count0", 32'(count), 32'd0);

    // 5: r0 writes are accepted and discarded
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hFFFF);
    check("t5_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("t5_count", 32'(count), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);
    step();
    check("t5_we", 32'(RegWrite), 32'd0);

    // 6: mid-operation reset drops queued writes (plus bypass checks)
    hold = 1'b1;
    drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd1, 16'h0002);
    step();
    idle();
`ifdef FORWARD_EN
    fwd_rs = 3'd1; fwd_rt = 3'd6;
    #1;
    check("fwd_hit1", 32'(fwd_hit1), 32'd1);
    check("fwd_data1", 32'(fwd_data1), 32'h0002);
    check("fwd_hit2", 32'(fwd_hit2), 32'd0);
    check("fwd_data2", 32'(fwd_data2), 32'h0000);
`endif
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0006);
    step();
    idle();
    check("t6_count3", 32'(count), 32'd3);
    check("t6_pending", 32'(pending), 32'h42);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    hold    = 1'b0;
    #1;
    check("t6_count0", 32'(count), 32'd0);
    check("t6_pending0", 32'(pending), 32'd0);
    check("t6_we", 32'(RegWrite), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_write", 32'(RegWrite), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
